// File: rtl/bus5_arb_pkg.sv
// Shared constants, owner codes and FSM state type for the five-source bus arbiter.
package bus5_arb_pkg;

    localparam int N_SRC = 5;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    localparam logic [SEL_W-1:0] SEL_A = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B = 3'd1;
    localparam logic [SEL_W-1:0] SEL_C = 3'd2;
    localparam logic [SEL_W-1:0] SEL_D = 3'd3;
    localparam logic [SEL_W-1:0] SEL_E = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Source after s, wrapping e -> a; codes 5..7 never reach here.
    function automatic logic [SEL_W-1:0] next_src(input logic [SEL_W-1:0] s);
        return (s == SEL_E) ? SEL_A : s + 3'd1;
    endfunction

endpackage

// File: rtl/bus5_rr_pick.sv
// Owner pick for the arbiter: round-robin from ptr, or fixed a>b>c>d>e when
// BUS5_ARB_FIXED_PRIO_EN is defined.
module bus5_rr_pick
    import bus5_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

`ifdef BUS5_ARB_FIXED_PRIO_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Descending scan so the lowest requesting index wins.
    always_comb begin
        found = 1'b0;
        idx   = SEL_A;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[3'(i)]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

`else

    function automatic logic [SEL_W-1:0] rot(input logic [SEL_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N_SRC) s = s - N_SRC;
        return 3'(s);
    endfunction

    // Descending offset scan so the source closest to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = SEL_A;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[rot(ptr, i)]) begin
                found = 1'b1;
                idx   = rot(ptr, i);
            end
        end
    end

`endif

endmodule

// File: rtl/bus5_arbiter.sv
// Five-source burst arbiter with a registered output beat and ready/valid handshake.
// Optional BUS5_ARB_FIXED_PRIO_EN switches the IDLE pick to fixed priority.
module bus5_arbiter
    import bus5_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  req,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [DATA_W-1:0] src_c,
    input  logic [DATA_W-1:0] src_d,
    input  logic [DATA_W-1:0] src_e,
    output logic [N_SRC-1:0]  ack,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic [DATA_W-1:0] mux_data;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              own_req;
    logic              accept;
    logic              burst_done;

    bus5_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        case (sel)
            SEL_A:   mux_data = src_a;
            SEL_B:   mux_data = src_b;
            SEL_C:   mux_data = src_c;
            SEL_D:   mux_data = src_d;
            SEL_E:   mux_data = src_e;
            default: mux_data = '0;
        endcase
    end

    assign own_req    = req[sel];
    assign accept     = (state == OWN) && own_req && (!out_valid || out_ready);
    // Only accepted beats advance the count, so stalls never shorten a burst.
    assign burst_done = (beat_cnt + 4'd1) == 4'(BURST_MAX);
    assign ack        = accept ? (5'd1 << sel) : '0;

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        ptr_nxt       = ptr;
        cnt_nxt       = beat_cnt;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;

        if (out_valid && out_ready) out_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    sel_nxt   = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_src(sel);
                end else if (accept) begin
                    out_data_nxt  = mux_data;
                    out_valid_nxt = 1'b1;
                    cnt_nxt       = beat_cnt + 4'd1;
                    if (burst_done) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_src(sel);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= SEL_A;
            ptr       <= SEL_A;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            ptr       <= ptr_nxt;
            beat_cnt  <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

endmodule

// File: tb/tb_bus5_arbiter.sv
// Self-checking bench for bus5_arbiter: directed scenarios plus random traffic
// against an owner/burst-count reference model.
module tb_bus5_arbiter;

    localparam int DW = 8;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    req = '0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] src [5];
    logic [DW-1:0] src_a, src_b, src_c, src_d, src_e;
    logic [4:0]    ack;
    logic [2:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;

    assign src_a = src[0];
    assign src_b = src[1];
    assign src_c = src[2];
    assign src_d = src[3];
    assign src_e = src[4];

    always #5 clk = ~clk;

    bus5_arbiter #(.DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .src_a(src_a), .src_b(src_b), .src_c(src_c), .src_d(src_d), .src_e(src_e),
        .ack(ack), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BUS5_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // Reference model: who owns the bus, how many beats it has had, where the
    // round-robin search starts, and what sits in the output register.
    bit            m_busy;
    logic [2:0]    m_own;
    logic [2:0]    m_ptr;
    int            m_cnt;
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [4:0]    e_ack;

    function automatic logic [2:0] m_pick(input logic [4:0] r, input logic [2:0] p);
        for (int k = 0; k < 5; k++) begin
            int j;
            j = (int'(p) + k) % 5;
            if (((r >> j) & 5'd1) != 5'd0) return 3'(j);
        end
        return 3'd0;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_ov = 0; m_od = '0;
    endtask

    task automatic m_eval();
        bit own_req;
        own_req = ((req >> m_own) & 5'd1) != 5'd0;
        e_ack = (m_busy && own_req && (!m_ov || out_ready)) ? (5'd1 << m_own) : 5'd0;
    endtask

    task automatic m_adv();
        bit own_req, consumed;
        own_req  = ((req >> m_own) & 5'd1) != 5'd0;
        consumed = m_ov && out_ready;
        if (!m_busy) begin
            if (consumed) m_ov = 0;
            if (req != 0) begin
                m_own  = m_pick(req, FIXED ? 3'd0 : m_ptr);
                m_cnt  = 0;
                m_busy = 1;
            end
        end else if (!own_req) begin
            if (consumed) m_ov = 0;
            m_ptr  = 3'((int'(m_own) + 1) % 5);
            m_busy = 0;
        end else if (!m_ov || out_ready) begin
            m_od = src[m_own];
            m_ov = 1;
            m_cnt++;
            if (m_cnt == BM) begin
                m_busy = 0;
                m_ptr  = 3'((int'(m_own) + 1) % 5);
            end
        end
    endtask

    task automatic rand_src();
        for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 5'b11111;
        @(negedge clk);
        #1;
        n_cmp += 4;
        if (sel !== 3'd0)      begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
        if (ack !== 5'b0)      begin n_bad++; $display("FAIL reset_ack got %b want 00000", ack); end
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            m_eval(); #1;
            n_cmp += 3;
            if (ack !== 5'b0)       begin n_bad++; $display("FAIL idle_ack c%0d got %b want 00000", c, ack); end
            if (sel !== 3'd0)       begin n_bad++; $display("FAIL idle_sel c%0d got %0d want 0", c, sel); end
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid c%0d got %b want 0", c, out_valid); end
            m_adv(); @(negedge clk);
        end
    endtask

    task automatic test_single_a();
        int acks = 0;
        apply_reset();
        out_ready = 1'b1;
        rand_src();
        src[0] = 8'h11;
        req = 5'b00001;
        for (int c = 0; c < 10; c++) begin
            m_eval(); #1;
            n_cmp += 4;
            if (ack !== e_ack)     begin n_bad++; $display("FAIL single_ack c%0d got %b want %b", c, ack, e_ack); end
            if (sel !== m_own)     begin n_bad++; $display("FAIL single_sel c%0d got %0d want %0d", c, sel, m_own); end
            if (out_valid !== m_ov) begin n_bad++; $display("FAIL single_valid c%0d got %b want %b", c, out_valid, m_ov); end
            if (m_ov && out_data !== 8'h11) begin n_bad++; $display("FAIL single_data c%0d got %h want 11", c, out_data); end
            if (ack[0] === 1'b1) acks++;
            m_adv(); @(negedge clk);
        end
        n_cmp++;
        if (acks != 8) begin n_bad++; $display("FAIL single_ack_count got %0d want 8", acks); end
    endtask

    task automatic test_all_req();
        int got[$];
        apply_reset();
        out_ready = 1'b1;
        req = 5'b11111;
        for (int c = 0; c < 31; c++) begin
            rand_src();
            m_eval(); #1;
            n_cmp += 4;
            if (ack !== e_ack)      begin n_bad++; $display("FAIL all_ack c%0d got %b want %b", c, ack, e_ack); end
            if (sel !== m_own)      begin n_bad++; $display("FAIL all_sel c%0d got %0d want %0d", c, sel, m_own); end
            if (out_valid !== m_ov) begin n_bad++; $display("FAIL all_valid c%0d got %b want %b", c, out_valid, m_ov); end
            if (out_data !== m_od)  begin n_bad++; $display("FAIL all_data c%0d got %h want %h", c, out_data, m_od); end
            for (int i = 0; i < 5; i++) if (ack[i] === 1'b1) got.push_back(i);
            m_adv(); @(negedge clk);
        end
        n_cmp++;
        if (got.size() != 24) begin n_bad++; $display("FAIL all_beats got %0d want 24", got.size()); end
        for (int k = 0; k < got.size() && k < 24; k++) begin
            int want;
            want = FIXED ? 0 : (k / BM) % 5;
            n_cmp++;
            if (got[k] != want) begin n_bad++; $display("FAIL grant_order beat%0d got %0d want %0d", k, got[k], want); end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held = '0;
        int acks = 0;
        apply_reset();
        req = 5'b00010;
        for (int c = 0; c < 11; c++) begin
            rand_src();
            out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            m_eval(); #1;
            n_cmp += 4;
            if (ack !== e_ack)      begin n_bad++; $display("FAIL bp_ack c%0d got %b want %b", c, ack, e_ack); end
            if (sel !== m_own)      begin n_bad++; $display("FAIL bp_sel c%0d got %0d want %0d", c, sel, m_own); end
            if (out_valid !== m_ov) begin n_bad++; $display("FAIL bp_valid c%0d got %b want %b", c, out_valid, m_ov); end
            if (out_data !== m_od)  begin n_bad++; $display("FAIL bp_data c%0d got %h want %h", c, out_data, m_od); end
            if (c == 1) held = src[1];
            if (c >= 2 && c <= 4) begin
                n_cmp += 2;
                if (ack !== 5'b0)     begin n_bad++; $display("FAIL bp_stall_ack c%0d got %b want 00000", c, ack); end
                if (out_data !== held) begin n_bad++; $display("FAIL bp_hold c%0d got %h want %h", c, out_data, held); end
            end
            if (c >= 5 && c <= 7 && ack[1] === 1'b1) acks++;
            if (c == 8) begin
                n_cmp++;
                if (ack !== 5'b0) begin n_bad++; $display("FAIL bp_release got %b want 00000", ack); end
            end
            m_adv(); @(negedge clk);
        end
        n_cmp++;
        if (acks != 3) begin n_bad++; $display("FAIL bp_resume_beats got %0d want 3", acks); end
        out_ready = 1'b1;
    endtask

    task automatic test_drop();
        apply_reset();
        out_ready = 1'b1;
        req = 5'b00100;
        for (int c = 0; c < 7; c++) begin
            rand_src();
            if (c == 3) req = 5'b10001;
            m_eval(); #1;
            n_cmp += 4;
            if (ack !== e_ack)      begin n_bad++; $display("FAIL drop_ack c%0d got %b want %b", c, ack, e_ack); end
            if (sel !== m_own)      begin n_bad++; $display("FAIL drop_sel c%0d got %0d want %0d", c, sel, m_own); end
            if (out_valid !== m_ov) begin n_bad++; $display("FAIL drop_valid c%0d got %b want %b", c, out_valid, m_ov); end
            if (out_data !== m_od)  begin n_bad++; $display("FAIL drop_data c%0d got %h want %h", c, out_data, m_od); end
            if (c == 3) begin
                n_cmp++;
                if (ack !== 5'b0) begin n_bad++; $display("FAIL drop_no_ack got %b want 00000", ack); end
            end
            if (c == 5) begin
                n_cmp += 2;
                if (ack !== (FIXED ? 5'b00001 : 5'b10000)) begin
                    n_bad++; $display("FAIL drop_next_owner got %b want %b", ack, FIXED ? 5'b00001 : 5'b10000);
                end
                if (sel !== (FIXED ? 3'd0 : 3'd4)) begin
                    n_bad++; $display("FAIL drop_next_sel got %0d want %0d", sel, FIXED ? 0 : 4);
                end
            end
            m_adv(); @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        apply_reset();
        out_ready = 1'b1;
        req = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            rand_src();
            m_eval(); #1;
            n_cmp += 2;
            if (ack !== e_ack)     begin n_bad++; $display("FAIL ar_ack c%0d got %b want %b", c, ack, e_ack); end
            if (out_data !== m_od) begin n_bad++; $display("FAIL ar_data c%0d got %h want %h", c, out_data, m_od); end
            m_adv(); @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (sel !== 3'd0)       begin n_bad++; $display("FAIL ar_sel got %0d want 0", sel); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin n_bad++; $display("FAIL ar_data got %h want 00", out_data); end
        if (ack !== 5'b0)       begin n_bad++; $display("FAIL ar_ack got %b want 00000", ack); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        req = 5'b11111;
        for (int c = 0; c < 5 && !seen; c++) begin
            #1;
            if (ack != 5'b0) begin
                seen = 1;
                n_cmp++;
                if (ack !== 5'b00001) begin n_bad++; $display("FAIL ar_first_owner got %b want 00001", ack); end
            end
            m_adv(); @(negedge clk);
        end
        if (!seen) begin n_cmp++; n_bad++; $display("FAIL ar_first_owner timeout got none want 00001"); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            rand_src();
            if ($urandom_range(3) == 0) req = 5'($urandom);
            out_ready = ($urandom_range(9) < 7);
            m_eval(); #1;
            n_cmp += 5;
            if (ack !== e_ack)      begin n_bad++; $display("FAIL rnd_ack c%0d got %b want %b", c, ack, e_ack); end
            if (sel !== m_own)      begin n_bad++; $display("FAIL rnd_sel c%0d got %0d want %0d", c, sel, m_own); end
            if (out_valid !== m_ov) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, out_valid, m_ov); end
            if (out_data !== m_od)  begin n_bad++; $display("FAIL rnd_data c%0d got %h want %h", c, out_data, m_od); end
            if ($countones(ack) > 1 || (ack & ~req) != 5'b0) begin
                n_bad++; $display("FAIL rnd_ack_legal c%0d got %b want onehot within %b", c, ack, req);
            end
            m_adv(); @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) src[i] = '0;
        m_reset();
        test_reset();
        test_single_a();
        test_all_req();
        test_backpressure();
        test_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
